// File: rtl/memreq_issue.sv
// memreq_issue: per-port read/write request buffering and single-slot issue stage in front of memblk.
// One request per cycle at most, read-after-write ordering per 64B line, bounded outstanding reads.
module memreq_issue #(
  parameter int unsigned RD_DEPTH = 8,
  parameter int unsigned WR_DEPTH = 4,
  parameter int unsigned MAX_RD   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         rd_valid,
  output logic         rd_ready,
  input  logic [38:0]  rd_addr,
  input  logic [39:0]  rd_phy,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [38:0]  wr_addr,
  input  logic [532:0] wr_data,
  input  logic         rd_ret,
  output logic [38:0]  rdaddr0,
  output logic [39:0]  rdphydata0,
  output logic         rden,
  output logic [38:0]  wraddr0,
  output logic [532:0] wrdata,
  output logic         wren,
  output logic [5:0]   rd_outst,
  output logic         credit_err
);

  localparam int unsigned AW  = 39;
  localparam int unsigned PW  = 40;
  localparam int unsigned DW  = 533;
  localparam int unsigned OW  = 6;
  localparam int unsigned LW  = 33;
  localparam int unsigned RPW = $clog2(RD_DEPTH);
  localparam int unsigned WPW = $clog2(WR_DEPTH);
  localparam int unsigned RCW = RPW + 1;
  localparam int unsigned WCW = WPW + 1;

  typedef enum logic {
    LAST_WR = 1'b0,
    LAST_RD = 1'b1
  } last_t;

  logic [AW-1:0] rd_addr_mem [RD_DEPTH];
  logic [PW-1:0] rd_phy_mem  [RD_DEPTH];
  logic [AW-1:0] wr_addr_mem [WR_DEPTH];
  logic [DW-1:0] wr_data_mem [WR_DEPTH];

  logic [RPW-1:0]      rd_wp, rd_rp;
  logic [RCW-1:0]      rd_cnt;
  logic [WPW-1:0]      wr_wp, wr_rp;
  logic [WCW-1:0]      wr_cnt;
  logic [WR_DEPTH-1:0] wr_vld;

  last_t last_q, last_d;

  logic          rd_push, wr_push;
  logic          issue_rd, issue_wr;
  logic          rd_elig, wr_elig, hazard;
  logic          ret_ok, ret_err;
  logic [OW-1:0] outst_eff, outst_nxt;
  logic [AW-1:0] rd_head;
  logic [LW-1:0] rd_head_line;

  // Ready depends on occupancy only; a same-edge pop never frees room for a push.
  assign rd_ready = (rd_cnt != RCW'(RD_DEPTH));
  assign wr_ready = (wr_cnt != WCW'(WR_DEPTH));
  assign rd_push  = rd_valid & rd_ready;
  assign wr_push  = wr_valid & wr_ready;

  assign rd_head      = rd_addr_mem[rd_rp];
  assign rd_head_line = rd_head[36:4];

  // Returns only count on stall-free edges; a return with nothing outstanding is a credit error.
  assign ret_ok    = ~stall & rd_ret & (rd_outst != '0);
  assign ret_err   = ~stall & rd_ret & (rd_outst == '0);
  assign outst_eff = rd_outst - OW'(ret_ok);
  assign outst_nxt = outst_eff + OW'(issue_rd);

  // Read head is blocked while any queued write targets the same line.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WR_DEPTH; i++) begin
      if (wr_vld[i] && (wr_addr_mem[i][36:4] == rd_head_line)) hazard = 1'b1;
    end
  end

  assign rd_elig = (rd_cnt != '0) && (outst_eff < OW'(MAX_RD)) && !hazard;
  assign wr_elig = (wr_cnt != '0);

  // Last-issued-type register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= LAST_WR;
    else      last_q <= last_d;
  end

  // Issue selection: alternate under contention, otherwise take whichever side is eligible.
  always_comb begin
    last_d   = last_q;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    if (!stall) begin
      if (rd_elig && (!wr_elig || (last_q == LAST_WR))) begin
        issue_rd = 1'b1;
        last_d   = LAST_RD;
      end else if (wr_elig) begin
        issue_wr = 1'b1;
        last_d   = LAST_WR;
      end
    end
  end

  // FIFO payload storage (no reset needed; validity tracked by counts).
  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_addr_mem[rd_wp] <= rd_addr;
      rd_phy_mem[rd_wp]  <= rd_phy;
    end
    if (wr_push) begin
      wr_addr_mem[wr_wp] <= wr_addr;
      wr_data_mem[wr_wp] <= wr_data;
    end
  end

  // Read FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wp  <= '0;
      rd_rp  <= '0;
      rd_cnt <= '0;
    end else begin
      if (rd_push)  rd_wp <= rd_wp + RPW'(1);
      if (issue_rd) rd_rp <= rd_rp + RPW'(1);
      case ({rd_push, issue_rd})
        2'b10:   rd_cnt <= rd_cnt + RCW'(1);
        2'b01:   rd_cnt <= rd_cnt - RCW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  // Write FIFO pointers, occupancy and per-slot valid bits for the hazard check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
      wr_vld <= '0;
    end else begin
      if (wr_push) begin
        wr_wp         <= wr_wp + WPW'(1);
        wr_vld[wr_wp] <= 1'b1;
      end
      if (issue_wr) begin
        wr_rp         <= wr_rp + WPW'(1);
        wr_vld[wr_rp] <= 1'b0;
      end
      case ({wr_push, issue_wr})
        2'b10:   wr_cnt <= wr_cnt + WCW'(1);
        2'b01:   wr_cnt <= wr_cnt - WCW'(1);
        default: wr_cnt <= wr_cnt;
      endcase
    end
  end

  // Issue registers toward memblk; frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdaddr0    <= '0;
      rdphydata0 <= '0;
      rden       <= 1'b0;
      wraddr0    <= '0;
      wrdata     <= '0;
      wren       <= 1'b0;
    end else if (!stall) begin
      rden <= issue_rd;
      wren <= issue_wr;
      if (issue_rd) begin
        rdaddr0    <= rd_head;
        rdphydata0 <= rd_phy_mem[rd_rp];
      end
      if (issue_wr) begin
        wraddr0 <= wr_addr_mem[wr_rp];
        wrdata  <= wr_data_mem[wr_rp];
      end
    end
  end

  // Outstanding-read counter and sticky credit error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_outst   <= '0;
      credit_err <= 1'b0;
    end else if (!stall) begin
      rd_outst   <= outst_nxt;
      credit_err <= credit_err | ret_err;
    end
  end

endmodule

// File: tb/tb_memreq_issue.sv
// Self-checking bench for memreq_issue: directed scenarios plus randomized traffic vs a queue model.
`timescale 1ns/1ps
module tb_memreq_issue;

  localparam int unsigned RD_DEPTH = 8;
  localparam int unsigned WR_DEPTH = 4;
  localparam int unsigned MAX_RD   = 2;

  logic         clk = 1'b0;
  logic         rst, stall, rd_valid, wr_valid, rd_ret;
  logic [38:0]  rd_addr, wr_addr;
  logic [39:0]  rd_phy;
  logic [532:0] wr_data;
  logic         rd_ready, wr_ready, rden, wren, credit_err;
  logic [38:0]  rdaddr0, wraddr0;
  logic [39:0]  rdphydata0;
  logic [532:0] wrdata;
  logic [5:0]   rd_outst;

  always #5 clk = ~clk;

  memreq_issue #(.RD_DEPTH(RD_DEPTH), .WR_DEPTH(WR_DEPTH), .MAX_RD(MAX_RD)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_phy(rd_phy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_ret(rd_ret),
    .rdaddr0(rdaddr0), .rdphydata0(rdphydata0), .rden(rden),
    .wraddr0(wraddr0), .wrdata(wrdata), .wren(wren),
    .rd_outst(rd_outst), .credit_err(credit_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: request queues plus the visible issue state.
  logic [38:0]  rq_a [$];
  logic [39:0]  rq_p [$];
  logic [38:0]  wq_a [$];
  logic [532:0] wq_d [$];
  int           m_outst;
  bit           m_err, m_last_wr, m_rden, m_wren;
  logic [38:0]  m_rdaddr, m_wraddr;
  logic [39:0]  m_rdphy;
  logic [532:0] m_wrdata;

  function automatic logic [38:0] mk_addr(input logic [32:0] line);
    logic [38:0] a;
    a[38:37] = 2'($urandom);
    a[36:4]  = line;
    a[3:0]   = 4'($urandom);
    return a;
  endfunction

  function automatic logic [532:0] rand_wdata();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[532:0];
  endfunction

  function automatic logic [39:0] rand_phy();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    rq_a.delete(); rq_p.delete(); wq_a.delete(); wq_d.delete();
    m_outst = 0; m_err = 0; m_last_wr = 1; m_rden = 0; m_wren = 0;
    m_rdaddr = '0; m_wraddr = '0; m_rdphy = '0; m_wrdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit rpush_ok, wpush_ok, retv, haz, r_el, w_el;
    int eff;
    logic [38:0] head, wa;
    rpush_ok = rq_a.size() < RD_DEPTH;
    wpush_ok = wq_a.size() < WR_DEPTH;
    if (!stall) begin
      retv = rd_ret && (m_outst > 0);
      if (rd_ret && m_outst == 0) m_err = 1;
      eff = m_outst - int'(retv);
      haz = 0;
      if (rq_a.size() > 0) begin
        head = rq_a[0];
        foreach (wq_a[i]) begin
          wa = wq_a[i];
          if (wa[36:4] == head[36:4]) haz = 1;
        end
      end
      r_el = (rq_a.size() > 0) && (eff < int'(MAX_RD)) && !haz;
      w_el = (wq_a.size() > 0);
      m_rden = 0;
      m_wren = 0;
      if (r_el && (!w_el || m_last_wr)) begin
        m_rdaddr = rq_a.pop_front();
        m_rdphy  = rq_p.pop_front();
        m_rden = 1; m_last_wr = 0; eff++;
      end else if (w_el) begin
        m_wraddr = wq_a.pop_front();
        m_wrdata = wq_d.pop_front();
        m_wren = 1; m_last_wr = 1;
      end
      m_outst = eff;
    end
    if (rd_valid && rpush_ok) begin rq_a.push_back(rd_addr); rq_p.push_back(rd_phy); end
    if (wr_valid && wpush_ok) begin wq_a.push_back(wr_addr); wq_d.push_back(wr_data); end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rd_valid = 0; wr_valid = 0; rd_ret = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 0; stall = 0; idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    rd_valid = 1; rd_addr = mk_addr(33'h11); rd_phy = rand_phy();
    wr_valid = 1; wr_addr = mk_addr(33'h22); wr_data = rand_wdata();
    tick();
    idle_inputs();
    tick();
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1; rd_addr = mk_addr(33'(8'h30 + i)); rd_phy = rand_phy();
      tick();
    end
    rd_addr = mk_addr(33'h40);
    rst = 0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({rden, wren, rd_outst, credit_err} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl got rden=%0b wren=%0b outst=%0d err=%0b exp all 0", rden, wren, rd_outst, credit_err);
    end
    checks++;
    if (rdaddr0 !== '0 || rdphydata0 !== '0 || wraddr0 !== '0 || wrdata !== '0) begin
      errors++; $display("FAIL reset_data got rdaddr0=%h wraddr0=%h exp 0", rdaddr0, wraddr0);
    end
    rst = 1; stall = 0; idle_inputs();
    @(negedge clk);
    checks++;
    if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got rd=%0b wr=%0b exp 1 1", rd_ready, wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rden !== 1'b0 || wren !== 1'b0) begin
        errors++; $display("FAIL reset_empty got rden=%0b wren=%0b exp 0 0", rden, wren);
      end
    end
  endtask

  task automatic test_contention();
    logic [38:0] ra [4];
    logic [38:0] wa [4];
    int seq [$];
    int ri, wi;
    apply_reset();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      ra[i] = mk_addr(33'(8'h50 + i)); wa[i] = mk_addr(33'(8'h60 + i));
      rd_valid = 1; rd_addr = ra[i]; rd_phy = rand_phy();
      wr_valid = 1; wr_addr = wa[i]; wr_data = rand_wdata();
      tick();
    end
    idle_inputs();
    stall = 0;
    ri = 0; wi = 0;
    for (int c = 0; c < 14; c++) begin
      rd_ret = (m_outst > 0);
      tick();
      checks++;
      if (rden && wren) begin
        errors++; $display("FAIL contention_both got rden=1 wren=1 exp at most one");
      end
      if (rden) begin
        seq.push_back(0);
        checks++;
        if (ri < 4 && rdaddr0 !== ra[ri]) begin
          errors++; $display("FAIL contention_rdaddr got %h exp %h", rdaddr0, ra[ri]);
        end
        ri++;
      end
      if (wren) begin
        seq.push_back(1);
        checks++;
        if (wi < 4 && wraddr0 !== wa[wi]) begin
          errors++; $display("FAIL contention_wraddr got %h exp %h", wraddr0, wa[wi]);
        end
        wi++;
      end
    end
    rd_ret = 0;
    checks++;
    if (seq.size() != 8) begin
      errors++; $display("FAIL contention_count got %0d exp 8", seq.size());
    end
    for (int i = 0; i < seq.size() && i < 8; i++) begin
      checks++;
      if (seq[i] != (i % 2)) begin
        errors++; $display("FAIL contention_order slot %0d got %0d exp %0d (0=R 1=W)", i, seq[i], i % 2);
      end
    end
  endtask

  task automatic test_raw_hazard();
    int seq [$];
    logic [38:0] got_rd;
    logic [38:0] a;
    apply_reset();
    stall = 1;
    wr_valid = 1; wr_addr = mk_addr(33'h100); wr_data = rand_wdata();
    tick();
    wr_valid = 0;
    rd_valid = 1; rd_addr = mk_addr(33'h100); rd_phy = rand_phy();
    tick();
    idle_inputs();
    stall = 0;
    got_rd = '0;
    for (int c = 0; c < 6; c++) begin
      rd_ret = (m_outst > 0);
      tick();
      if (rden) begin seq.push_back(0); got_rd = rdaddr0; end
      if (wren) seq.push_back(1);
    end
    rd_ret = 0;
    checks++;
    if (seq.size() != 2 || seq[0] != 1 || seq[1] != 0) begin
      errors++; $display("FAIL raw_order got %0d issues first=%0d exp 2 issues W then R", seq.size(), (seq.size() > 0) ? seq[0] : -1);
    end
    a = got_rd;
    checks++;
    if (a[36:4] !== 33'h100) begin
      errors++; $display("FAIL raw_rdline got %h exp 100", a[36:4]);
    end
  endtask

  task automatic test_credits();
    int n;
    apply_reset();
    stall = 0; rd_ret = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1; rd_addr = mk_addr(33'(8'h70 + i)); rd_phy = rand_phy();
      tick();
      if (i == 0) begin
        checks++;
        if (rden !== 1'b0) begin errors++; $display("FAIL latency_push_edge got rden=%0b exp 0", rden); end
      end
      if (i == 1) begin
        checks++;
        if (rden !== 1'b1) begin errors++; $display("FAIL latency_issue_edge got rden=%0b exp 1", rden); end
      end
      if (rden) n++;
    end
    rd_valid = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (rden) n++; end
    checks++;
    if (n != int'(MAX_RD)) begin errors++; $display("FAIL credits_limit got %0d reads exp %0d", n, MAX_RD); end
    checks++;
    if (rd_outst !== 6'(MAX_RD)) begin errors++; $display("FAIL credits_outst got %0d exp %0d", rd_outst, MAX_RD); end
    rd_ret = 1;
    tick();
    rd_ret = 0;
    n = rden ? 1 : 0;
    for (int i = 0; i < 6; i++) begin tick(); if (rden) n++; end
    checks++;
    if (n != 1) begin errors++; $display("FAIL credits_refill got %0d reads exp 1", n); end
    checks++;
    if (rd_outst !== 6'(MAX_RD)) begin errors++; $display("FAIL credits_outst2 got %0d exp %0d", rd_outst, MAX_RD); end
  endtask

  task automatic test_stall();
    logic [38:0] r1, r2;
    apply_reset();
    r1 = mk_addr(33'h81); r2 = mk_addr(33'h82);
    rd_valid = 1; rd_addr = r1; rd_phy = rand_phy();
    tick();
    rd_valid = 0;
    tick();
    stall = 1;
    rd_valid = 1; rd_addr = r2; rd_phy = rand_phy();
    tick();
    rd_valid = 0;
    for (int i = 0; i < 10; i++) begin
      rd_ret = i[0];
      tick();
      checks++;
      if (rden !== 1'b1 || wren !== 1'b0 || rdaddr0 !== r1 || rd_outst !== 6'd1 || credit_err !== 1'b0) begin
        errors++; $display("FAIL stall_hold got rden=%0b wren=%0b rdaddr0=%h outst=%0d err=%0b exp 1 0 %h 1 0", rden, wren, rdaddr0, rd_outst, credit_err, r1);
      end
    end
    stall = 0; rd_ret = 0;
    tick();
    checks++;
    if (rden !== 1'b1 || rdaddr0 !== r2 || rd_outst !== 6'd2) begin
      errors++; $display("FAIL stall_resume got rden=%0b rdaddr0=%h outst=%0d exp 1 %h 2", rden, rdaddr0, rd_outst, r2);
    end
  endtask

  task automatic test_full();
    logic [38:0] a [9];
    int k;
    apply_reset();
    stall = 1;
    for (int i = 0; i < 9; i++) begin
      a[i] = mk_addr(33'(8'h90 + i));
      checks++;
      if (rd_ready !== (i < 8)) begin errors++; $display("FAIL full_ready push %0d got %0b exp %0b", i, rd_ready, i < 8); end
      rd_valid = 1; rd_addr = a[i]; rd_phy = rand_phy();
      tick();
    end
    checks++;
    if (rd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after got %0b exp 0", rd_ready); end
    stall = 0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      rd_ret = (m_outst > 0);
      tick();
      rd_valid = 0;
      if (rden) begin
        checks++;
        if (k >= 8 || rdaddr0 !== a[k]) begin
          errors++; $display("FAIL full_drain read %0d got %h exp %h", k, rdaddr0, (k < 8) ? a[k] : 39'h0);
        end
        k++;
      end
    end
    checks++;
    if (k != 8) begin errors++; $display("FAIL full_drain_count got %0d exp 8", k); end
    checks++;
    if (credit_err !== 1'b0 || rd_outst !== 6'd0) begin
      errors++; $display("FAIL credit_pre got err=%0b outst=%0d exp 0 0", credit_err, rd_outst);
    end
    rd_ret = 1;
    tick();
    rd_ret = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (credit_err !== 1'b1 || rd_outst !== 6'd0) begin
        errors++; $display("FAIL credit_sticky got err=%0b outst=%0d exp 1 0", credit_err, rd_outst);
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      stall    = ($urandom_range(99) < 25);
      rd_valid = $urandom_range(1);
      rd_addr  = mk_addr(33'($urandom_range(3)));
      rd_phy   = rand_phy();
      wr_valid = ($urandom_range(2) == 0);
      wr_addr  = mk_addr(33'($urandom_range(3)));
      wr_data  = rand_wdata();
      rd_ret   = (m_outst > 0) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
      checks++;
      if (rd_ready !== (rq_a.size() < RD_DEPTH) || wr_ready !== (wq_a.size() < WR_DEPTH)) begin
        errors++; $display("FAIL rand_ready cyc %0d got %0b %0b exp %0b %0b", c, rd_ready, wr_ready, rq_a.size() < RD_DEPTH, wq_a.size() < WR_DEPTH);
      end
      tick();
      checks++;
      if (rden !== m_rden || wren !== m_wren || rd_outst !== 6'(m_outst) || credit_err !== m_err) begin
        errors++; $display("FAIL rand_ctrl cyc %0d got rden=%0b wren=%0b outst=%0d err=%0b exp %0b %0b %0d %0b", c, rden, wren, rd_outst, credit_err, m_rden, m_wren, m_outst, m_err);
      end
      checks++;
      if (rdaddr0 !== m_rdaddr || rdphydata0 !== m_rdphy) begin
        errors++; $display("FAIL rand_rd cyc %0d got %h/%h exp %h/%h", c, rdaddr0, rdphydata0, m_rdaddr, m_rdphy);
      end
      checks++;
      if (wraddr0 !== m_wraddr || wrdata !== m_wrdata) begin
        errors++; $display("FAIL rand_wr cyc %0d got addr %h exp %h", c, wraddr0, m_wraddr);
      end
    end
    idle_inputs();
    stall = 0;
  endtask

  initial begin
    rst = 0; stall = 0; idle_inputs();
    rd_addr = '0; rd_phy = '0; wr_addr = '0; wr_data = '0;
    model_reset();
    test_reset();
    test_contention();
    test_raw_hazard();
    test_credits();
    test_stall();
    test_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout exceeded 1000000 ns");
    $fatal(1);
  end

endmodule
